// File: rtl/dat_mem_copier.sv
// rtl/dat_mem_copier.sv - byte block copier mastering the single-port data memory (optional DAT_COPY_CHECKSUM_EN)
module dat_mem_copier #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
`ifdef DAT_COPY_CHECKSUM_EN
  output logic [DW-1:0] csum,
`endif
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hold_q, hold_d;
`ifdef DAT_COPY_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  // State and datapath registers; reset aborts any copy in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
`ifdef DAT_COPY_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
`ifdef DAT_COPY_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state logic: one byte moves per READ/WRITE pair, in ascending order.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
`ifdef DAT_COPY_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = len;
`ifdef DAT_COPY_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = (len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        hold_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_d   = src_q + AW'(1);
        dst_d   = dst_q + AW'(1);
        cnt_d   = cnt_q - AW'(1);
`ifdef DAT_COPY_CHECKSUM_EN
        csum_d  = csum_q + hold_q;
`endif
        state_d = (cnt_q == AW'(1)) ? S_DONE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    busy      = (state_q == S_READ) || (state_q == S_WRITE);
    done      = (state_q == S_DONE);
    mem_wr_en = (state_q == S_WRITE);
    mem_wdata = hold_q;
    mem_addr  = '0;
    if (state_q == S_READ) begin
      mem_addr = src_q;
    end else if (state_q == S_WRITE) begin
      mem_addr = dst_q;
    end
  end

`ifdef DAT_COPY_CHECKSUM_EN
  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_dat_mem_copier.sv
// tb/tb_dat_mem_copier.sv - directed self-checking bench for dat_mem_copier
module tb_dat_mem_copier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef DAT_COPY_CHECKSUM_EN
  logic [7:0] csum;
`endif

  logic [7:0] mem [0:255];

  int tests;
  int fails;

  dat_mem_copier #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
`ifdef DAT_COPY_CHECKSUM_EN
    .csum      (csum),
`endif
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on posedge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue start (sampled at edge 0) then observe cycles 1..budget at negedges.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                          input int extra, input int budget,
                          output int done_cyc, output int done_cnt,
                          output logic [63:0] busy_m, output logic [63:0] wr_m);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    done_cyc = -1;
    done_cnt = 0;
    busy_m   = '0;
    wr_m     = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == extra);
      if (busy) busy_m[c] = 1'b1;
      if (mem_wr_en) wr_m[c] = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    start = 1'b0;
  endtask

  int          dc;
  int          dn;
  logic [63:0] bm;
  logic [63:0] wm;
  int          late_done;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic copy of four bytes
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    run_copy(8'h10, 8'h40, 8'd4, 0, 12, dc, dn, bm, wm);
    check("basic_done_cyc", dc, 9);
    check("basic_done_cnt", dn, 1);
    check("basic_busy_mask", bm, 64'h1FE);
    check("basic_wr_mask", wm, 64'h154);
    check("basic_data", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 64'h44332211);

    // Zero length
    run_copy(8'h10, 8'h40, 8'd0, 0, 4, dc, dn, bm, wm);
    check("zero_done_cyc", dc, 1);
    check("zero_done_cnt", dn, 1);
    check("zero_busy_mask", bm, 0);
    check("zero_wr_mask", wm, 0);
    check("zero_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 64'h44332211);

    // Address wrap on the source side
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3;
    run_copy(8'hFE, 8'h01, 8'd3, 0, 10, dc, dn, bm, wm);
    check("wrap_done_cyc", dc, 7);
    check("wrap_data", {mem[8'h03], mem[8'h02], mem[8'h01]}, 64'hC3B2A1);
    check("wrap_wdata_hold", mem_wdata, 8'hC3);

    // Overlapping regions with an ignored start during busy
    mem[8'h20] = 8'h5A; mem[8'h21] = 8'h01; mem[8'h22] = 8'h02; mem[8'h23] = 8'h03;
    run_copy(8'h20, 8'h21, 8'd3, 3, 12, dc, dn, bm, wm);
    check("ovl_done_cyc", dc, 7);
    check("ovl_done_cnt", dn, 1);
    check("ovl_data", {mem[8'h23], mem[8'h22], mem[8'h21]}, 64'h5A5A5A);

    // Reset in cycle 5 of an eight-byte copy
    for (int i = 0; i < 8; i++) begin
      mem[8'h50 + i] = 8'h80 + 8'(i);
      mem[8'h60 + i] = 8'h00;
    end
    @(negedge clk);
    src_addr = 8'h50; dst_addr = 8'h60; len = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pre_wr_en", mem_wr_en, 1);
    @(posedge clk);
    #2;
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_en", mem_wr_en, 0);
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) late_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) late_done++;
    end
    check("mid_no_done", late_done, 0);
    check("mid_copied", {mem[8'h61], mem[8'h60]}, 64'h8180);
    check("mid_not_copied", mem[8'h62], 8'h00);

    // Fresh start after the abort
    mem[8'h70] = 8'h9C; mem[8'h71] = 8'h3D;
    run_copy(8'h70, 8'h90, 8'd2, 0, 8, dc, dn, bm, wm);
    check("fresh_done_cyc", dc, 5);
    check("fresh_data", {mem[8'h91], mem[8'h90]}, 64'h3D9C);

`ifdef DAT_COPY_CHECKSUM_EN
    // Checksum: FF + 02 + 10 = 0x111, truncated to 0x11
    mem[8'hA0] = 8'hFF; mem[8'hA1] = 8'h02; mem[8'hA2] = 8'h10;
    run_copy(8'hA0, 8'hB0, 8'd3, 0, 10, dc, dn, bm, wm);
    check("csum_done_cyc", dc, 7);
    check("csum_value", csum, 8'h11);
    @(negedge clk);
    src_addr = 8'hA0; dst_addr = 8'hC0; len = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("csum_clear", csum, 8'h00);
    repeat (4) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
